// File: rtl/timer_ctrl.sv
// Control FSM for a 4-digit mm:ss countdown timer with alarm.
// Define TIMER_CTRL_BLINK_EN to make alarm toggle on each tick in ALARM.
module timer_ctrl #(
  parameter int ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic [3:0] zero,
  output logic       load,
  output logic [3:0] digit_en,
  output logic       direction,
  output logic       alarm,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam logic [7:0] LAST_TICK = 8'(ALARM_TICKS - 1);

  state_t     st;
  logic [7:0] alm_cnt;
  logic       all_zero;
  logic       cnt_en;

  assign all_zero  = (zero == 4'hF);
  assign direction = 1'b0;
  assign state     = st;

  // A tick with clear is dropped; with stop it still counts.
  assign cnt_en = tick & (st == RUN) & ~all_zero & ~clear;

  // Borrow cascade: a digit steps only when all lower digits are zero.
  always_comb begin
    digit_en    = 4'b0000;
    digit_en[0] = cnt_en;
    digit_en[1] = cnt_en & zero[0];
    digit_en[2] = cnt_en & (&zero[1:0]);
    digit_en[3] = cnt_en & (&zero[2:0]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= IDLE;
      load    <= 1'b0;
      alarm   <= 1'b0;
      alm_cnt <= 8'd0;
    end else begin
      load <= 1'b0;
      if (clear) begin
        st      <= IDLE;
        load    <= 1'b1;
        alarm   <= 1'b0;
        alm_cnt <= 8'd0;
      end else begin
        unique case (st)
          IDLE: begin
            if (!stop && start && !all_zero)
              st <= RUN;
          end
          RUN: begin
            unique case (1'b1)
              stop: st <= PAUSE;
              all_zero: begin
                st      <= ALARM;
                alarm   <= 1'b1;
                alm_cnt <= 8'd0;
              end
              default: ;
            endcase
          end
          PAUSE: begin
            unique case (1'b1)
              stop: begin
                st   <= IDLE;
                load <= 1'b1;
              end
              start: st <= RUN;
              default: ;
            endcase
          end
          ALARM: begin
            if (stop || (tick && alm_cnt == LAST_TICK)) begin
              st      <= IDLE;
              load    <= 1'b1;
              alarm   <= 1'b0;
              alm_cnt <= 8'd0;
            end else if (tick) begin
              alm_cnt <= alm_cnt + 8'd1;
`ifdef TIMER_CTRL_BLINK_EN
              alarm   <= ~alarm;
`else
              alarm   <= 1'b1;
`endif
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule
